// File: rtl/reg_rename_ctrl_pkg.sv
// Shared rename constants and types; RNDEPTH/RNBIT must match the physical register file.
package reg_rename_ctrl_pkg;

    localparam int unsigned RNDEPTH   = 4;
    localparam int unsigned RNBIT     = 2;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned IDXBIT    = 5;

    typedef logic [RNBIT-1:0]  rn_ptr_t;
    typedef logic [IDXBIT-1:0] arch_idx_t;

    typedef struct packed {
        logic [RNDEPTH-1:0] alloc;
        logic [RNDEPTH-1:0] written;
        rn_ptr_t            spec_ptr;
        rn_ptr_t            arch_ptr;
    } slot_state_t;

    localparam slot_state_t SLOT_RESET = '{
        alloc:    RNDEPTH'(1),
        written:  RNDEPTH'(1),
        spec_ptr: '0,
        arch_ptr: '0
    };

    // Lowest-numbered clear bit; result is meaningless when every copy is allocated.
    function automatic rn_ptr_t lowest_free(logic [RNDEPTH-1:0] alloc);
        rn_ptr_t p;
        p = '0;
        for (int c = int'(RNDEPTH) - 1; c >= 0; c--) begin
            if (!alloc[c]) p = rn_ptr_t'(c);
        end
        return p;
    endfunction

endpackage

// File: rtl/reg_rename_ctrl_if.sv
// Dispatch, lookup, writeback, commit and flush signals of the rename controller.
interface reg_rename_ctrl_if;
    import reg_rename_ctrl_pkg::*;

    logic      alloc_valid;
    arch_idx_t alloc_index;
    logic      alloc_ready;
    rn_ptr_t   alloc_rename;

    arch_idx_t rs1_index;
    rn_ptr_t   rs1_rename;
    logic      rs1_written;
    arch_idx_t rs2_index;
    rn_ptr_t   rs2_rename;
    logic      rs2_written;

    logic      wb_valid;
    arch_idx_t wb_index;
    rn_ptr_t   wb_rename;

    logic      cmt_valid;
    arch_idx_t cmt_index;
    rn_ptr_t   cmt_rename;
    logic      cmt_err;

    logic      flush;

    modport master (
        output alloc_valid, alloc_index, rs1_index, rs2_index,
               wb_valid, wb_index, wb_rename, cmt_valid, cmt_index, cmt_rename, flush,
        input  alloc_ready, alloc_rename, rs1_rename, rs1_written, rs2_rename, rs2_written,
               cmt_err
    );

    modport slave (
        input  alloc_valid, alloc_index, rs1_index, rs2_index,
               wb_valid, wb_index, wb_rename, cmt_valid, cmt_index, cmt_rename, flush,
        output alloc_ready, alloc_rename, rs1_rename, rs1_written, rs2_rename, rs2_written,
               cmt_err
    );

endinterface

// File: rtl/reg_rename_ctrl_rename_slot.sv
// Rename state of one architectural register; enables arrive already decoded and qualified.
module rename_slot
    import reg_rename_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        alloc_en,
    input  rn_ptr_t     alloc_copy,
    input  logic        wb_en,
    input  rn_ptr_t     wb_copy,
    input  logic        cmt_en,
    input  rn_ptr_t     cmt_copy,
    input  logic        flush,
    output slot_state_t state
);

    slot_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d.spec_ptr = state_q.arch_ptr;
            for (int c = 0; c < int'(RNDEPTH); c++) begin
                if (RNBIT'(c) != state_q.arch_ptr) begin
                    state_d.alloc[c]   = 1'b0;
                    state_d.written[c] = 1'b0;
                end
            end
        end else begin
            if (wb_en && state_q.alloc[wb_copy]) begin
                state_d.written[wb_copy] = 1'b1;
            end
            if (alloc_en) begin
                state_d.alloc[alloc_copy]   = 1'b1;
                state_d.written[alloc_copy] = 1'b0;
                state_d.spec_ptr            = alloc_copy;
            end
            // Applied last: frees the old arch copy, which never collides with the alloc target.
            if (cmt_en) begin
                state_d.alloc[state_q.arch_ptr]   = 1'b0;
                state_d.written[state_q.arch_ptr] = 1'b0;
                state_d.arch_ptr                  = cmt_copy;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= SLOT_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/reg_rename_ctrl.sv
// Rename allocator/tracker: hands out free copies, tracks writeback and commit, restores on flush.
module reg_rename_ctrl
    import reg_rename_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTn,
    reg_rename_ctrl_if.slave bus
);

    slot_state_t slot_st [ARCH_REGS];
    slot_state_t a_st, c_st, r1_st, r2_st;
    logic        any_free, alloc_fire, wb_fire, cmt_legal, cmt_fire, cmt_err_q;

    // x0 reads as a permanently written copy 0 and never changes.
    assign slot_st[0] = SLOT_RESET;

    assign a_st  = slot_st[bus.alloc_index];
    assign c_st  = slot_st[bus.cmt_index];
    assign r1_st = slot_st[bus.rs1_index];
    assign r2_st = slot_st[bus.rs2_index];

    assign any_free         = ~&a_st.alloc;
    assign bus.alloc_ready  = (bus.alloc_index == '0) ? 1'b1 : (any_free && !bus.flush);
    assign bus.alloc_rename = (bus.alloc_index == '0) ? '0 : lowest_free(a_st.alloc);
    assign alloc_fire       = bus.alloc_valid && bus.alloc_ready && (bus.alloc_index != '0);

    assign bus.rs1_rename  = r1_st.spec_ptr;
    assign bus.rs1_written = r1_st.written[r1_st.spec_ptr];
    assign bus.rs2_rename  = r2_st.spec_ptr;
    assign bus.rs2_written = r2_st.written[r2_st.spec_ptr];

    assign wb_fire   = bus.wb_valid && (bus.wb_index != '0);
    // Judged on registered state, so a same-cycle writeback cannot legalise a commit.
    assign cmt_legal = c_st.alloc[bus.cmt_rename] && c_st.written[bus.cmt_rename] &&
                       (bus.cmt_rename != c_st.arch_ptr);
    assign cmt_fire  = bus.cmt_valid && (bus.cmt_index != '0) && cmt_legal;

    for (genvar i = 1; i < int'(ARCH_REGS); i++) begin : g_slot
        rename_slot u_slot (
            .CLK        (CLK),
            .RSTn       (RSTn),
            .alloc_en   (alloc_fire && (bus.alloc_index == arch_idx_t'(i))),
            .alloc_copy (bus.alloc_rename),
            .wb_en      (wb_fire && (bus.wb_index == arch_idx_t'(i))),
            .wb_copy    (bus.wb_rename),
            .cmt_en     (cmt_fire && (bus.cmt_index == arch_idx_t'(i))),
            .cmt_copy   (bus.cmt_rename),
            .flush      (bus.flush),
            .state      (slot_st[i])
        );
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cmt_err_q <= 1'b0;
        end else begin
            cmt_err_q <= bus.cmt_valid && (bus.cmt_index != '0) && !bus.flush && !cmt_legal;
        end
    end

    assign bus.cmt_err = cmt_err_q;

endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a per-register array model.
module tb_reg_rename_ctrl;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    reg_rename_ctrl_if bus ();

    reg_rename_ctrl dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    // Reference model: plain arrays per architectural register.
    bit m_alloc [32][4];
    bit m_wr    [32][4];
    int m_spec  [32];
    int m_arch  [32];
    bit m_err;

    function automatic int m_free(int r);
        for (int c = 0; c < 4; c++) if (!m_alloc[r][c]) return c;
        return -1;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 4; c++) begin
                m_alloc[r][c] = (c == 0);
                m_wr[r][c]    = (c == 0);
            end
            m_spec[r] = 0;
            m_arch[r] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step();
        bit na [32][4];
        bit nw [32][4];
        int ns [32];
        int nar[32];
        bit nerr, legal;
        int ai, wi, wc, ci, cc, g;
        na = m_alloc; nw = m_wr; ns = m_spec; nar = m_arch; nerr = 0;
        ai = int'(bus.alloc_index); wi = int'(bus.wb_index); wc = int'(bus.wb_rename);
        ci = int'(bus.cmt_index); cc = int'(bus.cmt_rename);
        if (bus.flush) begin
            for (int r = 1; r < 32; r++) begin
                ns[r] = m_arch[r];
                for (int c = 0; c < 4; c++) if (c != m_arch[r]) begin na[r][c] = 0; nw[r][c] = 0; end
            end
        end else begin
            if (bus.wb_valid && wi != 0 && m_alloc[wi][wc]) nw[wi][wc] = 1;
            g = m_free(ai);
            if (bus.alloc_valid && ai != 0 && g >= 0) begin
                na[ai][g] = 1; nw[ai][g] = 0; ns[ai] = g;
            end
            legal = m_alloc[ci][cc] && m_wr[ci][cc] && cc != m_arch[ci];
            if (bus.cmt_valid && ci != 0) begin
                if (legal) begin
                    na[ci][m_arch[ci]] = 0; nw[ci][m_arch[ci]] = 0; nar[ci] = cc;
                end else begin
                    nerr = 1;
                end
            end
        end
        m_alloc = na; m_wr = nw; m_spec = ns; m_arch = nar; m_err = nerr;
    endtask

    task automatic drive_idle();
        bus.alloc_valid = 0; bus.alloc_index = '0; bus.rs1_index = '0; bus.rs2_index = '0;
        bus.wb_valid = 0; bus.wb_index = '0; bus.wb_rename = '0;
        bus.cmt_valid = 0; bus.cmt_index = '0; bus.cmt_rename = '0; bus.flush = 0;
    endtask

    task automatic tick();
        if (RSTn) model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        model_reset();
        RSTn = 0;
        #12 RSTn = 1;
        @(posedge CLK); #1;
        bus.rs1_index = 5'd5; bus.alloc_index = 5'd5; #1;
        n_vec++; if (bus.rs1_rename !== 2'd0) begin n_err++; $display("FAIL reset_rs1_rename: got %0d expected 0", bus.rs1_rename); end
        n_vec++; if (bus.rs1_written !== 1'b1) begin n_err++; $display("FAIL reset_rs1_written: got %0b expected 1", bus.rs1_written); end
        n_vec++; if (bus.alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready: got %0b expected 1", bus.alloc_ready); end
        n_vec++; if (bus.alloc_rename !== 2'd1) begin n_err++; $display("FAIL reset_alloc_rename: got %0d expected 1", bus.alloc_rename); end
        n_vec++; if (bus.cmt_err !== 1'b0) begin n_err++; $display("FAIL reset_cmt_err: got %0b expected 0", bus.cmt_err); end
    endtask

    task automatic test_alloc_full();
        for (int k = 1; k <= 3; k++) begin
            drive_idle(); bus.alloc_valid = 1; bus.alloc_index = 5'd5; bus.rs1_index = 5'd5; #1;
            n_vec++; if (bus.alloc_rename !== 2'(k)) begin n_err++; $display("FAIL full_grant: got %0d expected %0d", bus.alloc_rename, k); end
            tick();
            n_vec++; if (bus.rs1_rename !== 2'(k)) begin n_err++; $display("FAIL full_rs1_follow: got %0d expected %0d", bus.rs1_rename, k); end
        end
        n_vec++; if (bus.alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b expected 0", bus.alloc_ready); end
        tick();
        n_vec++; if (bus.rs1_rename !== 2'd3) begin n_err++; $display("FAIL full_stall_nochange: got %0d expected 3", bus.rs1_rename); end
        drive_idle(); bus.wb_valid = 1; bus.wb_index = 5'd5; bus.wb_rename = 2'd1; tick();
        drive_idle(); bus.cmt_valid = 1; bus.cmt_index = 5'd5; bus.cmt_rename = 2'd1; bus.alloc_index = 5'd5; #1;
        n_vec++; if (bus.alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_free_same_cycle: got %0b expected 0", bus.alloc_ready); end
        tick();
        drive_idle(); bus.alloc_index = 5'd5; #1;
        n_vec++; if (bus.alloc_ready !== 1'b1 || bus.alloc_rename !== 2'd0) begin
            n_err++; $display("FAIL full_regrant: got ready=%0b rename=%0d expected ready=1 rename=0", bus.alloc_ready, bus.alloc_rename); end
        n_vec++; if (bus.cmt_err !== 1'b0) begin n_err++; $display("FAIL full_cmt_err: got %0b expected 0", bus.cmt_err); end
    endtask

    task automatic test_same_cycle();
        drive_idle(); bus.alloc_valid = 1; bus.alloc_index = 5'd7; bus.rs1_index = 5'd7; #1;
        n_vec++; if (bus.rs1_rename !== 2'd0) begin n_err++; $display("FAIL same_rs1_pre: got %0d expected 0", bus.rs1_rename); end
        tick();
        drive_idle(); bus.rs1_index = 5'd7; #1;
        n_vec++; if (bus.rs1_rename !== 2'd1 || bus.rs1_written !== 1'b0) begin
            n_err++; $display("FAIL same_rs1_post: got rename=%0d written=%0b expected 1/0", bus.rs1_rename, bus.rs1_written); end
        bus.wb_valid = 1; bus.wb_index = 5'd7; bus.wb_rename = 2'd1; #1;
        n_vec++; if (bus.rs1_written !== 1'b0) begin n_err++; $display("FAIL same_wb_early: got %0b expected 0", bus.rs1_written); end
        tick();
        drive_idle(); bus.rs1_index = 5'd7; #1;
        n_vec++; if (bus.rs1_written !== 1'b1) begin n_err++; $display("FAIL same_wb_late: got %0b expected 1", bus.rs1_written); end
    endtask

    task automatic test_flush();
        drive_idle(); bus.alloc_valid = 1; bus.alloc_index = 5'd3; tick(); tick();
        drive_idle(); bus.wb_valid = 1; bus.wb_index = 5'd3; bus.wb_rename = 2'd1; tick();
        bus.wb_rename = 2'd2; tick();
        drive_idle(); bus.cmt_valid = 1; bus.cmt_index = 5'd3; bus.cmt_rename = 2'd1; tick();
        drive_idle(); bus.flush = 1; bus.alloc_index = 5'd3; #1;
        n_vec++; if (bus.alloc_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %0b expected 0", bus.alloc_ready); end
        bus.alloc_valid = 1; tick();
        drive_idle(); bus.rs1_index = 5'd3; bus.alloc_index = 5'd3; #1;
        n_vec++; if (bus.rs1_rename !== 2'd1 || bus.rs1_written !== 1'b1) begin
            n_err++; $display("FAIL flush_spec: got rename=%0d written=%0b expected 1/1", bus.rs1_rename, bus.rs1_written); end
        n_vec++; if (bus.alloc_rename !== 2'd0) begin n_err++; $display("FAIL flush_regrant: got %0d expected 0", bus.alloc_rename); end
    endtask

    task automatic test_illegal_commit();
        drive_idle(); bus.cmt_valid = 1; bus.cmt_index = 5'd9; bus.cmt_rename = 2'd2; tick();
        drive_idle(); bus.rs1_index = 5'd9; bus.alloc_index = 5'd9; #1;
        n_vec++; if (bus.cmt_err !== 1'b1) begin n_err++; $display("FAIL illegal_err_set: got %0b expected 1", bus.cmt_err); end
        n_vec++; if (bus.rs1_rename !== 2'd0 || bus.alloc_rename !== 2'd1) begin
            n_err++; $display("FAIL illegal_nochange: got spec=%0d grant=%0d expected 0/1", bus.rs1_rename, bus.alloc_rename); end
        tick();
        n_vec++; if (bus.cmt_err !== 1'b0) begin n_err++; $display("FAIL illegal_err_pulse: got %0b expected 0", bus.cmt_err); end
        drive_idle(); bus.alloc_valid = 1; bus.alloc_index = 5'd0; bus.rs1_index = 5'd0; #1;
        n_vec++; if (bus.alloc_ready !== 1'b1 || bus.alloc_rename !== 2'd0) begin
            n_err++; $display("FAIL x0_alloc: got ready=%0b rename=%0d expected 1/0", bus.alloc_ready, bus.alloc_rename); end
        tick();
        n_vec++; if (bus.rs1_rename !== 2'd0 || bus.rs1_written !== 1'b1) begin
            n_err++; $display("FAIL x0_read: got rename=%0d written=%0b expected 0/1", bus.rs1_rename, bus.rs1_written); end
    endtask

    task automatic test_random();
        int ai, r1, r2, cr, g;
        bit er;
        for (int n = 0; n < 600; n++) begin
            drive_idle();
            ai = $urandom_range(0, 7); r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7);
            bus.alloc_valid = 1'($urandom_range(0, 1)); bus.alloc_index = 5'(ai);
            bus.rs1_index = 5'(r1); bus.rs2_index = 5'(r2);
            bus.wb_valid = ($urandom_range(0, 2) != 0); bus.wb_index = 5'($urandom_range(0, 7));
            bus.wb_rename = 2'($urandom_range(0, 3));
            cr = $urandom_range(0, 7);
            bus.cmt_valid = ($urandom_range(0, 2) == 0); bus.cmt_index = 5'(cr);
            bus.cmt_rename = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_spec[cr]);
            bus.flush = ($urandom_range(0, 24) == 0);
            #1;
            g = m_free(ai);
            er = (ai == 0) ? 1'b1 : (!bus.flush && g >= 0);
            n_vec++; if (bus.alloc_ready !== er) begin n_err++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", ai, bus.alloc_ready, er); end
            if (er) begin
                n_vec++; if (bus.alloc_rename !== 2'((ai == 0) ? 0 : g)) begin
                    n_err++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", ai, bus.alloc_rename, (ai == 0) ? 0 : g); end
            end
            n_vec++; if (bus.rs1_rename !== 2'(m_spec[r1]) || bus.rs1_written !== m_wr[r1][m_spec[r1]]) begin
                n_err++; $display("FAIL rnd_rs1[%0d]: got %0d/%0b expected %0d/%0b", r1, bus.rs1_rename, bus.rs1_written, m_spec[r1], m_wr[r1][m_spec[r1]]); end
            n_vec++; if (bus.rs2_rename !== 2'(m_spec[r2]) || bus.rs2_written !== m_wr[r2][m_spec[r2]]) begin
                n_err++; $display("FAIL rnd_rs2[%0d]: got %0d/%0b expected %0d/%0b", r2, bus.rs2_rename, bus.rs2_written, m_spec[r2], m_wr[r2][m_spec[r2]]); end
            n_vec++; if (bus.cmt_err !== m_err) begin n_err++; $display("FAIL rnd_cmt_err: got %0b expected %0b", bus.cmt_err, m_err); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive_idle(); bus.alloc_valid = 1;
        for (int r = 1; r <= 4; r++) begin bus.alloc_index = 5'(r); tick(); tick(); end
        drive_idle(); bus.cmt_valid = 1; bus.cmt_index = 5'd2; bus.cmt_rename = 2'd2; tick();
        drive_idle(); #1;
        n_vec++; if (bus.cmt_err !== 1'b1) begin n_err++; $display("FAIL mid_err_before: got %0b expected 1", bus.cmt_err); end
        RSTn = 0;
        model_reset();
        #1;
        n_vec++; if (bus.cmt_err !== 1'b0) begin n_err++; $display("FAIL mid_cmt_err: got %0b expected 0", bus.cmt_err); end
        for (int r = 1; r <= 4; r++) begin
            bus.rs1_index = 5'(r); bus.alloc_index = 5'(r); #1;
            n_vec++; if (bus.rs1_rename !== 2'd0 || bus.rs1_written !== 1'b1 || bus.alloc_rename !== 2'd1) begin
                n_err++; $display("FAIL mid_reg[%0d]: got spec=%0d wr=%0b grant=%0d expected 0/1/1", r, bus.rs1_rename, bus.rs1_written, bus.alloc_rename); end
        end
        @(negedge CLK); RSTn = 1;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_alloc_full();
        test_same_cycle();
        test_flush();
        test_illegal_commit();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_rename_ctrl.md
Name: reg_rename_ctrl

Overview:
- Allocator and tracker for the renamed physical register file (32 architectural registers × RNDEPTH copies each).
- The register file consumes {index, rename} selects; this block produces them.
- Hands out a free copy per destination register at dispatch, gives the current speculative copy for source operands, marks copies written at writeback, and frees the superseded copy at commit.
- Flush restores the committed mapping.

Parameters:
- RNDEPTH, 4, copies per architectural register.
- RNBIT, 2, rename pointer width; log2(RNDEPTH).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- alloc_valid  input  1  dispatch requests a new copy for alloc_index.
- alloc_index  input  5  destination architectural register.
- alloc_ready  output  1  a free copy exists for alloc_index; independent of alloc_valid.
- alloc_rename  output  RNBIT  copy granted; valid when alloc_ready.
- rs1_index  input  5  source 1 architectural register.
- rs1_rename  output  RNBIT  current speculative copy of rs1_index.
- rs1_written  output  1  that copy has been written back.
- rs2_index  input  5  source 2 architectural register.
- rs2_rename  output  RNBIT  as rs1.
- rs2_written  output  1  as rs1.
- wb_valid  input  1  writeback of copy {wb_index, wb_rename}.
- wb_index  input  5  writeback register.
- wb_rename  input  RNBIT  writeback copy.
- cmt_valid  input  1  retire of {cmt_index, cmt_rename}.
- cmt_index  input  5  retiring register.
- cmt_rename  input  RNBIT  retiring copy.
- flush  input  1  mispredict/exception recovery.
- cmt_err  output  1  registered pulse on an illegal commit.

Behaviour:
- The clock and reset port names are CLK and RSTn. There is one clock. Reset is asynchronous and active-low.

Per-register state (regs 1..31):
- alloc[RNDEPTH], written[RNDEPTH], spec_ptr, arch_ptr.

Reset values:
- Copy 0 has alloc=1 and written=1. All other copies have alloc=0 and written=0.
- spec_ptr=arch_ptr=0.
- cmt_err=0.

Register x0:
- alloc_ready=1 and alloc_rename=0. No state change.
- rs*_rename=0 and rs*_written=1.
- wb and cmt to x0 are ignored.

Allocation:
- alloc_ready = (any alloc bit of alloc_index is 0) && !flush.
- alloc_rename is the lowest-numbered free copy.
- On alloc_valid && alloc_ready, at the next edge: alloc[c]=1, written[c]=0, spec_ptr=c.
- Full condition: all RNDEPTH copies allocated gives alloc_ready=0. Dispatch stalls; there is no state change.

Source lookup:
- Purely combinational from registered state.
- A same-cycle allocation to the same index is not visible. The read returns the pre-allocation spec_ptr, and dispatch orders rs reads before rd allocation.

Writeback:
- At the next edge, written[wb_rename]=1.
- Writeback to an unallocated copy is ignored.

Commit:
- Legal only if the copy is allocated, written, and not equal to arch_ptr.
- At the next edge: alloc[arch_ptr]=0, written[arch_ptr]=0, arch_ptr=cmt_rename.
- An illegal commit leaves state unchanged and sets cmt_err=1 for exactly one cycle.

Simultaneous events on the same index:
- A copy freed by commit is not allocatable until the cycle after.
- Allocation and commit both apply (the commit frees the old arch copy; the allocation takes a different copy).
- Writeback and commit of the same copy in the same cycle: the commit is illegal, because written is sampled from registered state.

Flush (highest priority):
- At the next edge, for every register: spec_ptr=arch_ptr, and every copy other than arch_ptr is cleared (alloc=0, written=0).
- The arch copy stays allocated and written.
- Allocation, writeback and commit presented in the flush cycle are dropped.

Reset mid-operation:
- All state returns to reset values immediately (asynchronous). Outputs follow combinationally.

Latency:
- Lookups are 0-cycle combinational.
- All updates take 1 cycle.

Decomposition:
- Shared package holds:
  - RNDEPTH and RNBIT constants (shared with the register file).
  - ARCH_REGS=32.
  - A typedef for the rename pointer.
  - A struct {alloc, written, spec_ptr, arch_ptr}.
- One sub-module, rename_slot, holds the per-register state and its update logic, instanced 31 times.
- The top level does:
  - index decode to the slots,
  - lowest-free-copy priority encode,
  - read muxing for the rs ports,
  - cmt_err generation.

Test Plan:
- Reset, then read rs1_index=5 -> rs1_rename=0, rs1_written=1; alloc_index=5 -> alloc_ready=1, alloc_rename=1.
- Allocate x5 three times -> grants 1,2,3 and rs1_rename follows 1,2,3. A fourth request gives alloc_ready=0. Commit x5 copy 1 after wb -> copy 0 freed next cycle; alloc then grants 0.
- Same-cycle alloc x7 with rs1_index=7 -> rs1_rename=0 that cycle and 1 the next cycle; rs1_written=0 until wb x7 copy 1, then 1 the cycle after.
- Allocate x3→1 and x3→2, write back both, commit x3 copy 1, then flush -> spec_ptr(x3)=1; copies 0 and 2 free; the next alloc x3 grants 0.
- Commit x9 copy 2 while it is unallocated -> cmt_err=1 for one cycle; x9 state unchanged. Alloc x0 -> alloc_rename=0 with no state change.
- Assert RSTn=0 mid-sequence with several copies allocated -> immediately all spec_ptr=0, only copy 0 allocated per register, cmt_err=0.
